// File: rtl/address_seq_pkg.sv
// Shared types and constants for the BRAM address-generator run controller.
package address_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_PRIME = 2'd2,
        S_RUN   = 2'd3
    } seq_state_t;

    localparam int CFG_EN      = 0;
    localparam int CFG_OUT     = 1;
    localparam int LOAD_CYCLES = 2;

    // Generator control bits implied by a sequencer state.
    function automatic logic [1:0] cfg_for_state(seq_state_t s);
        logic [1:0] c;
        c = 2'b00;
        case (s)
            S_PRIME: c[CFG_EN] = 1'b1;
            S_RUN: begin
                c[CFG_EN]  = 1'b1;
                c[CFG_OUT] = 1'b1;
            end
            default: c = 2'b00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Loadable down-counter; flags a generator that stops producing restart pulses.
module seq_watchdog #(
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          kick_i,
    input  logic          enable_i,
    input  logic [CW-1:0] load_i,
    output logic          expired_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (kick_i) begin
            cnt_d = load_i;
        end else if (enable_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == '0);

endmodule

// File: rtl/address_sequencer.sv
// Run controller: latches a host period, sequences the generator reset/prime/run
// phases, counts restart pulses and aborts on a stalled generator.
module address_sequencer
    import address_seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NCW       = 16,
    parameter int WD_MARGIN = 8
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic           stop,
    input  logic           continuous,
    input  logic [31:0]    period_in,
    input  logic [NCW-1:0] n_periods,
    input  logic           restart,
    input  logic           tvalid,
    output logic [31:0]    cfg,
    output logic [31:0]    period,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [NCW-1:0] period_count
);

    localparam logic [31:0] PERIOD_MAX = 32'((64'd1 << WIDTH) - 64'd1);
    // Wide enough for PERIOD_MAX + WD_MARGIN - 1.
    localparam int WDW = $clog2((2 ** WIDTH) + WD_MARGIN);
    localparam logic [WDW-1:0] WD_OFF = WDW'(WD_MARGIN - 1);

    seq_state_t     state_q, state_d;
    logic           start_q;
    logic [31:0]    period_q, period_d;
    logic [NCW-1:0] nper_q, nper_d;
    logic           cont_q, cont_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
    logic [NCW-1:0] pcnt_q, pcnt_d;
    logic [1:0]     cfg_q, cfg_d;
    logic           busy_q, busy_d;
    logic [1:0]     lcnt_q, lcnt_d;

    logic           start_rise;
    logic           params_bad;
    logic [NCW-1:0] pcnt_inc;
    logic           wd_kick, wd_en, wd_exp;
    logic [WDW-1:0] wd_load;
    logic           tvalid_unused;

    assign tvalid_unused = tvalid;
    assign start_rise    = start && !start_q;
    assign params_bad    = (period_in == 32'd0) || (period_in > PERIOD_MAX) ||
                           ((n_periods == '0) && !continuous);
    assign pcnt_inc      = pcnt_q + NCW'(1);

    assign wd_en   = (state_q == S_PRIME) || (state_q == S_RUN);
    // Expiry shows up period + WD_MARGIN cycles after the reload edge.
    assign wd_load = WDW'(period_q[WIDTH-1:0]) + WD_OFF;

    seq_watchdog #(.CW(WDW)) u_wd (
        .clk       (clk),
        .resetn    (resetn),
        .kick_i    (wd_kick),
        .enable_i  (wd_en),
        .load_i    (wd_load),
        .expired_o (wd_exp)
    );

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        nper_d   = nper_q;
        cont_d   = cont_q;
        done_d   = done_q;
        error_d  = error_q;
        pcnt_d   = pcnt_q;
        lcnt_d   = lcnt_q;
        wd_kick  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_rise && !stop) begin
                    if (params_bad) begin
                        error_d = 1'b1;
                    end else begin
                        period_d = period_in;
                        nper_d   = n_periods;
                        cont_d   = continuous;
                        done_d   = 1'b0;
                        error_d  = 1'b0;
                        pcnt_d   = '0;
                        lcnt_d   = 2'd0;
                        state_d  = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (lcnt_q == 2'(LOAD_CYCLES - 1)) begin
                    state_d = S_PRIME;
                    wd_kick = 1'b1;
                end else begin
                    lcnt_d = lcnt_q + 2'd1;
                end
            end
            S_PRIME: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (restart) begin
                    state_d = S_RUN;
                    wd_kick = 1'b1;
                end else if (wd_exp) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // A restart beats a same-cycle expiry; stop beats both.
                if (stop) begin
                    state_d = S_IDLE;
                end else if (restart) begin
                    pcnt_d  = pcnt_inc;
                    wd_kick = 1'b1;
                    if (!cont_q && (pcnt_inc == nper_q)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (wd_exp) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cfg_d  = cfg_for_state(state_d);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            period_q <= '0;
            nper_q   <= '0;
            cont_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            pcnt_q   <= '0;
            cfg_q    <= 2'b00;
            busy_q   <= 1'b0;
            lcnt_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            period_q <= period_d;
            nper_q   <= nper_d;
            cont_q   <= cont_d;
            done_q   <= done_d;
            error_q  <= error_d;
            pcnt_q   <= pcnt_d;
            cfg_q    <= cfg_d;
            busy_q   <= busy_d;
            lcnt_q   <= lcnt_d;
        end
    end

    assign cfg          = {30'd0, cfg_q};
    assign period       = period_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign period_count = pcnt_q;

endmodule

// File: doc/address_sequencer.md
# address_sequencer

Run controller for the BRAM address generator. It latches a host-requested period, then drives the generator's `cfg`/`period` inputs through a fixed reset → prime → run sequence. It counts generator `restart` pulses to stop after N periods, or runs continuously, and flags a stalled generator. It sits between the host configuration registers and the address generator inside the acquisition/playback system.

## Interface
- `WIDTH`, 8, generator address width; sets `PERIOD_MAX = 2**WIDTH - 1`
- `NCW`, 16, width of the period-count registers
- `WD_MARGIN`, 8, extra watchdog cycles beyond `period`
- `clk` in 1: the block's single clock
- `resetn` in 1: asynchronous, active-low reset
- `start` in 1: host level; a rising edge launches a run
- `stop` in 1: host level; while high, forces abort
- `continuous` in 1: sampled at launch; 1 = ignore `n_periods`
- `period_in` in 32: requested generator period
- `n_periods` in NCW: number of periods per run
- `restart` in 1: generator wrap pulse
- `tvalid` in 1: generator valid; monitored only
- `cfg` out 32: to generator; bit0 = count enable, bit1 = output enable, bits 31:2 = 0
- `period` out 32: to generator; latched period
- `busy` out 1: high in LOAD/PRIME/RUN
- `done` out 1: sticky; set on normal completion
- `error` out 1: sticky; set on bad parameters or watchdog timeout
- `period_count` out NCW: restarts counted in RUN

## Operation
- **States:** IDLE, LOAD, PRIME, RUN.
- **IDLE:**
  - `cfg = 0`.
  - On `start` rising edge with `stop = 0`:
    - First check parameters. If `period_in == 0`, or `period_in > PERIOD_MAX`, or (`n_periods == 0` and `continuous == 0`): set `error`, stay in IDLE.
    - Otherwise: latch `period`, `n_periods`, `continuous`; clear `done`, `error`, `period_count`; go to LOAD.
- **LOAD:**
  - `cfg = 0` for exactly 2 cycles, so the generator sees the new period while held in reset.
  - Then go to PRIME.
- **PRIME:**
  - `cfg = 1`.
  - On the first `restart`, go to RUN.
- **RUN:**
  - `cfg = 3`.
  - Each `restart` increments `period_count`.
  - Non-continuous: the restart that brings `period_count` to `n_periods` sets `done` and returns to IDLE.
  - Continuous: `period_count` wraps modulo 2^NCW; the block stays in RUN.
- **Watchdog:**
  - In PRIME and RUN, a counter reloads on every `restart` and on state entry.
  - If it reaches `period + WD_MARGIN` with no `restart`: set `error`, go to IDLE.
- **Stop:** `stop = 1` in any non-IDLE state → IDLE next cycle; `done` is not set.
- **Boundary rules:**
  - `start` edge while busy: ignored.
  - `start` edge and `stop` in the same cycle: stop wins, no launch.
  - `restart` in the same cycle as `stop`: not counted.
  - `restart` in the same cycle as a watchdog expiry: the restart wins.
  - `start` held high across a completion: no relaunch until low then high again.
  - `tvalid` high in IDLE/LOAD: no action.
- **Reset:** `resetn` low at any time → IDLE immediately. Reset values: `cfg = 0`, `period = 0`, `busy = 0`, `done = 0`, `error = 0`, `period_count = 0`, `start` edge detector cleared.

## Timing
- All outputs are registered.
- `start` rising edge sampled at cycle t → LOAD at t+1 (`busy = 1`, `period` valid); PRIME at t+3 (`cfg = 1`).
- `restart` sampled at cycle k in PRIME → `cfg = 3` at k+1.
- Final `restart` at cycle k in RUN → at k+1: `cfg = 0`, `done = 1`, `busy = 0`, `period_count = n_periods`.
- `stop` sampled at cycle k → `cfg = 0` at k+1.
- Watchdog expiry → `error = 1` and `cfg = 0` in the same edge.
- `period_count` updates 1 cycle after `restart`.

## Structure
- Package `address_seq_pkg`:
  - state enum `seq_state_t`
  - cfg bit index constants `CFG_EN = 0`, `CFG_OUT = 1`
  - `LOAD_CYCLES = 2`
- Sub-module `seq_watchdog`: loadable down-counter with `kick`, `enable` and `expired` outputs.
- FSM, start edge detect, parameter check and counters live in `address_sequencer`.

## Test plan
- **Single run:** `WIDTH = 8`, `period_in = 255`, `n_periods = 3`; generator model restarts every 256 cycles.
  - `cfg` goes 0 → 1 → 3 → 0.
  - `period_count = 3`, `done = 1`, `busy = 0`.
  - Exactly 3 RUN restarts counted.
- **Continuous run:** `NCW = 4`, `continuous = 1`, 20 restarts.
  - `period_count` wraps 15 → 0 → 4.
  - `stop` → `cfg = 0` next cycle; `done = 0`.
- **Bad parameters:** `period_in = 0`, then `period_in = 256`, then `n_periods = 0` with `continuous = 0`.
  - `error = 1` each time.
  - `busy` never rises; `cfg` stays 0.
- **Stalled generator:** suppress `restart` in PRIME.
  - `error = 1` exactly `period + 8` cycles after PRIME entry; `cfg = 0`.
- **Simultaneous events:** `start` edge with `stop = 1` → no launch. `restart` coincident with `stop` → `period_count` unchanged.
- **Mid-run reset:** `resetn` low mid-RUN → all outputs 0 asynchronously. After release, a fresh `start` edge completes a normal run.
